// File: rtl/mouse_proximity_scanner.sv
// Scans N_OBJ object positions against a latched mouse position, flags close objects
// with hysteresis and reports the nearest one (Chebyshev metric), publishing atomically.
module mouse_proximity_scanner #(
  parameter int N_OBJ     = 8,
  parameter int FRAC_BITS = 12,
  parameter int THRESH    = 20,
  parameter int HYST      = 2,
  localparam int IW       = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      x_mouse,
  input  logic [31:0]      y_mouse,
  output logic [IW-1:0]    obj_idx,
  input  logic [31:0]      obj_x,
  input  logic [31:0]      obj_y,
  output logic             busy,
  output logic             done,
  output logic [N_OBJ-1:0] close_mask,
  output logic [N_OBJ-1:0] dir_mask,
  output logic             any_close,
  output logic [IW-1:0]    nearest_idx
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N_OBJ - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, PUBLISH} state_t;

  state_t state, state_nxt;

  logic [IW-1:0]    idx_nxt;
  logic             accept;
  logic [31:0]      xm, ym;
  logic             eval_vld;
  logic [IW-1:0]    eval_idx;

  logic [N_OBJ-1:0] sh_close, sh_dir;
  logic             sh_any;
  logic [IW-1:0]    sh_best_idx;
  logic [31:0]      sh_best_dist;

  logic [N_OBJ-1:0] sh_close_nxt, sh_dir_nxt;
  logic             sh_any_nxt;
  logic [IW-1:0]    sh_best_idx_nxt;
  logic [31:0]      sh_best_dist_nxt;

  logic [31:0]      dx, dy, ax, ay, ix, iy, cheb;
  logic             was_close, obj_close;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = obj_idx;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        idx_nxt = '0;
        if (start) begin
          state_nxt = SCAN;
          accept    = 1'b1;
        end
      end
      SCAN: begin
        busy = 1'b1;
        if (obj_idx == LAST_IDX) state_nxt = DRAIN;
        else                     idx_nxt   = obj_idx + 1'b1;
      end
      DRAIN: begin
        busy      = 1'b1;
        state_nxt = PUBLISH;
        idx_nxt   = '0;
      end
      PUBLISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Absolute values are taken unsigned so the most negative difference stays maximally far.
  always_comb begin
    dx        = obj_x - xm;
    dy        = ym - obj_y;
    ax        = dx[31] ? (32'd0 - dx) : dx;
    ay        = dy[31] ? (32'd0 - dy) : dy;
    ix        = ax >> FRAC_BITS;
    iy        = ay >> FRAC_BITS;
    cheb      = (ax > ay) ? ax : ay;
    was_close = close_mask[eval_idx];
    obj_close = ((ix < 32'(THRESH)) && (iy < 32'(THRESH))) ||
                (was_close && (ix < 32'(THRESH + HYST)) && (iy < 32'(THRESH + HYST)));
  end

  // Objects arrive in index order, so a strict compare keeps the lowest index on ties.
  always_comb begin
    sh_close_nxt     = sh_close;
    sh_dir_nxt       = sh_dir;
    sh_any_nxt       = sh_any;
    sh_best_idx_nxt  = sh_best_idx;
    sh_best_dist_nxt = sh_best_dist;
    if (eval_vld) begin
      sh_close_nxt[eval_idx] = obj_close;
      sh_dir_nxt[eval_idx]   = dx[31];
      if (obj_close && (!sh_any || (cheb < sh_best_dist))) begin
        sh_any_nxt       = 1'b1;
        sh_best_idx_nxt  = eval_idx;
        sh_best_dist_nxt = cheb;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      obj_idx      <= '0;
      eval_vld     <= 1'b0;
      eval_idx     <= '0;
      xm           <= '0;
      ym           <= '0;
      sh_close     <= '0;
      sh_dir       <= '0;
      sh_any       <= 1'b0;
      sh_best_idx  <= '0;
      sh_best_dist <= '0;
      close_mask   <= '0;
      dir_mask     <= '0;
      any_close    <= 1'b0;
      nearest_idx  <= '0;
    end else begin
      obj_idx  <= idx_nxt;
      eval_vld <= (state == SCAN);
      eval_idx <= obj_idx;
      if (accept) begin
        xm           <= x_mouse;
        ym           <= y_mouse;
        sh_close     <= '0;
        sh_dir       <= '0;
        sh_any       <= 1'b0;
        sh_best_idx  <= '0;
        sh_best_dist <= '0;
      end else begin
        sh_close     <= sh_close_nxt;
        sh_dir       <= sh_dir_nxt;
        sh_any       <= sh_any_nxt;
        sh_best_idx  <= sh_best_idx_nxt;
        sh_best_dist <= sh_best_dist_nxt;
      end
      // The last object is folded in on the same edge that enters PUBLISH.
      if (state == DRAIN) begin
        close_mask  <= sh_close_nxt;
        dir_mask    <= sh_dir_nxt;
        any_close   <= sh_any_nxt;
        nearest_idx <= sh_best_idx_nxt;
      end
    end
  end

endmodule

// File: tb/tb_mouse_proximity_scanner.sv
// Directed bench for mouse_proximity_scanner with N_OBJ=4 and a one-cycle-latency
// object memory; expected values are hand-computed per scenario.
module tb_mouse_proximity_scanner;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   x_mouse, y_mouse;
  logic [IW-1:0] obj_idx;
  logic [31:0]   obj_x, obj_y;
  logic          busy, done;
  logic [N-1:0]  close_mask, dir_mask;
  logic          any_close;
  logic [IW-1:0] nearest_idx;

  logic [31:0]   mem_x [N];
  logic [31:0]   mem_y [N];

  int checks = 0;
  int passed = 0;

  mouse_proximity_scanner #(.N_OBJ(N), .FRAC_BITS(12), .THRESH(20), .HYST(2)) dut (
    .clk(clk), .rst(rst), .start(start), .x_mouse(x_mouse), .y_mouse(y_mouse),
    .obj_idx(obj_idx), .obj_x(obj_x), .obj_y(obj_y), .busy(busy), .done(done),
    .close_mask(close_mask), .dir_mask(dir_mask), .any_close(any_close),
    .nearest_idx(nearest_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    obj_x <= mem_x[obj_idx];
    obj_y <= mem_y[obj_idx];
  end

  function automatic logic [31:0] fx(input int v);
    return 32'(v * 4096);
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic set_far();
    for (int i = 0; i < N; i++) begin
      mem_x[i] = fx(500);
      mem_y[i] = fx(500);
    end
  endtask

  task automatic check_results(input string tag, input logic [3:0] c, input logic [3:0] d,
                               input logic a, input logic [1:0] n);
    check_output({tag, "_close"},   32'(close_mask),  32'(c));
    check_output({tag, "_dir"},     32'(dir_mask),    32'(d));
    check_output({tag, "_any"},     32'(any_close),   32'(a));
    check_output({tag, "_nearest"}, 32'(nearest_idx), 32'(n));
  endtask

  // Pulses start for one cycle and waits (bounded) for done, checking its latency.
  task automatic apply_stimulus(input logic [31:0] mx, input logic [31:0] my, input bit sync);
    int n;
    bit seen;
    if (!sync) @(negedge clk);
    x_mouse = mx;
    y_mouse = my;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    x_mouse = 32'hDEAD_BEEF;
    y_mouse = 32'hDEAD_BEEF;
    check_output("busy_first", 32'(busy), 32'd1);
    check_output("idx_first", 32'(obj_idx), 32'd0);
    n = 1;
    seen = 1'b0;
    while (!seen && n < 20) begin
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check_output("done_latency", 32'(n), 32'd6);
    check_output("busy_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    check_output("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    int dones;
    rst     = 1'b1;
    start   = 1'b0;
    x_mouse = '0;
    y_mouse = '0;
    set_far();
    repeat (3) @(negedge clk);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_idx", 32'(obj_idx), 32'd0);
    check_results("rst", 4'b0000, 4'b0000, 1'b0, 2'd0);
    rst = 1'b0;

    $display("[TB] basic pass");
    mem_x[0] = fx(100); mem_y[0] = fx(50);
    apply_stimulus(fx(110), fx(50), 1'b0);
    check_results("basic", 4'b0001, 4'b0001, 1'b1, 2'd0);

    $display("[TB] threshold boundary");
    set_far();
    mem_x[1] = 32'h0001_4000; mem_y[1] = 32'd0;
    mem_x[2] = 32'h0001_3FFF; mem_y[2] = 32'd0;
    apply_stimulus(32'd0, 32'd0, 1'b0);
    check_results("boundary", 4'b0100, 4'b0000, 1'b1, 2'd2);

    $display("[TB] hysteresis");
    set_far();
    mem_x[3] = fx(19); mem_y[3] = 32'd0;
    apply_stimulus(32'd0, 32'd0, 1'b0);
    check_results("hyst1", 4'b1000, 4'b0000, 1'b1, 2'd3);
    mem_x[3] = fx(21);
    mem_x[1] = fx(21); mem_y[1] = 32'd0;
    apply_stimulus(32'd0, 32'd0, 1'b0);
    check_results("hyst2", 4'b1000, 4'b0000, 1'b1, 2'd3);
    set_far();
    mem_x[3] = fx(22); mem_y[3] = 32'd0;
    apply_stimulus(32'd0, 32'd0, 1'b0);
    check_results("hyst3", 4'b0000, 4'b0000, 1'b0, 2'd0);

    $display("[TB] nearest tie and fractional ranking");
    set_far();
    mem_x[1] = fx(5);  mem_y[1] = fx(3);
    mem_x[2] = fx(-7); mem_y[2] = fx(2);
    mem_x[3] = fx(2);  mem_y[3] = fx(-5);
    apply_stimulus(32'd0, 32'd0, 1'b0);
    check_results("tie", 4'b1110, 4'b0100, 1'b1, 2'd1);
    set_far();
    mem_x[1] = 32'h0000_4C00; mem_y[1] = 32'd0;
    mem_x[3] = 32'h0000_4800; mem_y[3] = 32'd0;
    apply_stimulus(32'd0, 32'd0, 1'b0);
    check_results("frac", 4'b1010, 4'b0000, 1'b1, 2'd3);

    $display("[TB] wrap-around difference");
    set_far();
    mem_x[0] = 32'h8000_0000; mem_y[0] = 32'd0;
    apply_stimulus(32'd0, 32'd0, 1'b0);
    check_results("wrap", 4'b0000, 4'b0001, 1'b0, 2'd0);

    $display("[TB] start while busy");
    set_far();
    mem_x[0] = fx(100); mem_y[0] = fx(50);
    @(negedge clk);
    x_mouse = fx(110); y_mouse = fx(50); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        dones++;
        start = 1'b1;
      end
    end
    start = 1'b0;
    check_output("ignored_start_dones", 32'(dones), 32'd1);
    check_results("ignored", 4'b0001, 4'b0001, 1'b1, 2'd0);

    $display("[TB] reset mid-pass");
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1; start = 1'b1;
    @(negedge clk); rst = 1'b0; start = 1'b0;
    check_output("midrst_busy", 32'(busy), 32'd0);
    check_output("midrst_done", 32'(done), 32'd0);
    check_output("midrst_idx", 32'(obj_idx), 32'd0);
    check_results("midrst", 4'b0000, 4'b0000, 1'b0, 2'd0);
    apply_stimulus(fx(110), fx(50), 1'b1);
    check_results("after_rst", 4'b0001, 4'b0001, 1'b1, 2'd0);

    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
